minterm_scanner: RTL and testbench
==================================

# minterm_scanner

Sequential truth-table extractor for 4-input Boolean functions: the inverse of the gate-level function circuits. It drives every input combination {A,B,C,D} into two function circuits under test and samples their F1/F2 outputs. It records each function as a 16-bit minterm mask, then streams the minterm indices out over a valid/ready handshake. It sits beside the F1/F2 circuits in the lab bench and checks that a minimized implementation still covers exactly the specified minterm list.

## Interface
- SAMPLE_DLY, default 0: extra settle cycles per input vector before F1/F2 are sampled (0 = purely combinational DUT).
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last minterm beat is accepted, or when the scan ends with empty masks.
- A, B, C, D  out  1 each  registered drive to the DUT; index = {A,B,C,D}, A is the MSB.
- f1, f2  in  1 each  DUT outputs F1, F2.
- mask1, mask2  out  16  bit i = function value at minterm i; stable from done until the next accepted start.
- m_valid  out  1  minterm beat valid.
- m_ready  in  1  consumer accepts beat.
- m_sel  out  1  0 = beat belongs to F1, 1 = beat belongs to F2.
- m_index  out  4  minterm number.
- m_last  out  1  final beat of the whole scan.

## Operation
- FSM states: IDLE, DRIVE, EMIT.
- IDLE → DRIVE on start:
  - clears mask1 and mask2;
  - sets vector counter v = 0 and settle counter s = 0.
- DRIVE:
  - {A,B,C,D} = v.
  - When s == SAMPLE_DLY: write mask1[v] <= f1 and mask2[v] <= f2, set s = 0, then v++. Otherwise s++.
  - After sampling v = 15, go to EMIT with scan pointer p = 0.
- EMIT:
  - p runs 0..31. Bits 0..15 map to mask1, bits 16..31 map to mask2.
  - Clear bit: p++ with no beat, one cycle.
  - Set bit: assert m_valid with m_sel = p[4] and m_index = p[3:0]. Hold until m_ready, then p++.
  - m_last = 1 when no set bit exists above p in {mask2,mask1}.
  - After the m_last beat is accepted, or when p passes 31 with no beat, pulse done and go to IDLE.
  - Both masks zero: no beats, done only.
- Beats are in ascending order: all F1 minterms, then all F2 minterms.
- start outside IDLE is ignored.
- A–D hold their last driven value outside DRIVE.

## Timing
- Reset values:
  - state IDLE;
  - busy 0, done 0, m_valid 0, m_last 0, m_sel 0, m_index 0;
  - A, B, C, D all 0;
  - mask1 and mask2 both 0x0000.
- Reset mid-operation aborts in the same edge. No done pulse is produced and the masks are cleared.
- DRIVE lasts exactly 16·(SAMPLE_DLY+1) cycles.
- f1/f2 are sampled at the clock edge ending the last settle cycle of each vector.
- busy rises the cycle after start is accepted and falls together with the done pulse.
- Handshake:
  - m_index, m_sel and m_last are stable while m_valid && !m_ready.
  - m_valid never drops without acceptance.
  - A beat transfers on m_valid && m_ready.
- With m_ready tied high, EMIT lasts at most 32 cycles.

## Structure
- Shared package minterm_pkg holds:
  - constants N_VARS = 4 and N_MINTERMS = 16;
  - the state enum {IDLE, DRIVE, EMIT};
  - width localparams for the vector and pointer counters.
- Natural sub-module: minterm_emitter. It takes the 32-bit concatenated mask and a start strobe, and contains the pointer, handshake and m_last lookahead.
- The top level holds the FSM, vector/settle counters and mask registers.

## Test plan
- F1 = (0,1,2,3,4,6,8,9,10,11) and F2 = (3,5,7,8,10,11,13,15) circuits attached, SAMPLE_DLY = 0, m_ready = 1:
  - mask1 = 0x0F5F, mask2 = 0xADA8;
  - 18 beats: 10 with m_sel = 0, then 8 with m_sel = 1;
  - last beat is (1,15) with m_last = 1; done pulses on that beat.
- Same DUT, SAMPLE_DLY = 2:
  - DRIVE takes 48 cycles;
  - the {A,B,C,D} sequence is 0..15, each held 3 cycles;
  - masks are identical to the first scenario.
- m_ready randomly low about 50% of cycles:
  - beat order and values are unchanged;
  - fields are stable while stalled;
  - exactly 18 transfers occur.
- f1 = 0, f2 = 1:
  - mask1 = 0x0000, mask2 = 0xFFFF;
  - 16 beats, m_sel = 1, m_index 0..15, m_last on 15.
- f1 = f2 = 0:
  - masks are zero, no m_valid;
  - done pulses; busy lasts 16 + 32 cycles (SAMPLE_DLY = 0).
- rst asserted during DRIVE at v = 7, then start reissued:
  - outputs return to reset values next cycle with no done pulse;
  - the second scan produces correct masks.

Source files
------------

// File: rtl/minterm_pkg.sv
// Shared constants, state encoding and scan helpers for the minterm scanner.
// Vector counter covers the 16 input combinations; scan pointer covers {mask2,mask1}.
package minterm_pkg;

    localparam int N_VARS     = 4;
    localparam int N_MINTERMS = 16;
    localparam int VEC_W      = N_VARS;
    localparam int PTR_W      = N_VARS + 1;
    localparam int SCAN_BITS  = 2 * N_MINTERMS;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        EMIT
    } state_t;

    typedef logic [VEC_W-1:0]     vec_t;
    typedef logic [PTR_W-1:0]     ptr_t;
    typedef logic [SCAN_BITS-1:0] scan_t;

    // True when any bit strictly above position p is set.
    function automatic logic any_above(input scan_t bits, input ptr_t p);
        scan_t keep;
        keep = ~((scan_t'(2) << p) - scan_t'(1));
        return |(bits & keep);
    endfunction

endpackage

// File: rtl/minterm_emitter.sv
// Walks the 32-bit {mask2,mask1} word and emits one valid/ready beat per set bit.
// Clear bits cost one cycle each; the end-of-scan strobe fires on the final transfer.
module minterm_emitter
    import minterm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  scan_t            mask,
    input  logic             m_ready,
    output logic             m_valid,
    output logic             m_sel,
    output logic [VEC_W-1:0] m_index,
    output logic             m_last,
    output logic             fin
);

    logic active;
    ptr_t p;
    logic hit;
    logic step;
    logic at_end;

    // Beat fields come straight from the pointer so they cannot move during a stall.
    assign hit     = mask[p];
    assign at_end  = (p == ptr_t'(SCAN_BITS - 1));
    assign m_valid = active && hit;
    assign m_sel   = p[PTR_W-1];
    assign m_index = p[VEC_W-1:0];
    assign m_last  = m_valid && !any_above(mask, p);
    assign step    = active && (!hit || m_ready);
    assign fin     = active && ((m_valid && m_ready && m_last) || (!hit && at_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            p      <= '0;
        end else if (start) begin
            active <= 1'b1;
            p      <= '0;
        end else if (fin) begin
            active <= 1'b0;
            p      <= '0;
        end else if (step) begin
            p <= p + ptr_t'(1);
        end
    end

endmodule

// File: rtl/minterm_scanner.sv
// Drives all 16 {A,B,C,D} vectors into two function circuits, records F1/F2 as
// minterm masks, then streams the set minterm indices out over valid/ready.
module minterm_scanner
    import minterm_pkg::*;
#(
    parameter int SAMPLE_DLY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        f1,
    input  logic        f2,
    output logic [15:0] mask1,
    output logic [15:0] mask2,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sel,
    output logic [3:0]  m_index,
    output logic        m_last
);

    localparam int             S_W   = (SAMPLE_DLY > 0) ? $clog2(SAMPLE_DLY + 1) : 1;
    localparam logic [S_W-1:0] S_MAX = S_W'(SAMPLE_DLY);

    state_t         state;
    vec_t           v;
    logic [S_W-1:0] s;
    logic           last_vec;
    logic           emit_start;
    logic           emit_fin;

    assign last_vec   = (v == vec_t'(N_MINTERMS - 1));
    assign emit_start = (state == DRIVE) && (s == S_MAX) && last_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            v            <= '0;
            s            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            {A, B, C, D} <= '0;
            mask1        <= '0;
            mask2        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= DRIVE;
                        busy         <= 1'b1;
                        v            <= '0;
                        s            <= '0;
                        {A, B, C, D} <= '0;
                        mask1        <= '0;
                        mask2        <= '0;
                    end
                end
                DRIVE: begin
                    if (s == S_MAX) begin
                        mask1[v] <= f1;
                        mask2[v] <= f2;
                        s        <= '0;
                        // The drive pins stay on vector 15 once the sweep completes.
                        if (last_vec) begin
                            state <= EMIT;
                        end else begin
                            v            <= v + vec_t'(1);
                            {A, B, C, D} <= v + vec_t'(1);
                        end
                    end else begin
                        s <= s + S_W'(1);
                    end
                end
                EMIT: begin
                    if (emit_fin) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    minterm_emitter u_emit (
        .clk     (clk),
        .rst     (rst),
        .start   (emit_start),
        .mask    ({mask2, mask1}),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_sel   (m_sel),
        .m_index (m_index),
        .m_last  (m_last),
        .fin     (emit_fin)
    );

endmodule

// File: tb/tb_minterm_scanner.sv
// Scoreboard bench: scans push expected beats, a negedge monitor pops and compares.
module tb_minterm_scanner;

    typedef struct packed {
        logic       sel;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        m_ready = 1'b1;
    logic        busy, done, A, B, C, D, f1, f2;
    logic [15:0] mask1, mask2;
    logic        m_valid, m_sel, m_last;
    logic [3:0]  m_index;

    logic        start2 = 1'b0;
    logic        busy2, done2, A2, B2, C2, D2, f1_2, f2_2;
    logic [15:0] mask1_2, mask2_2;
    logic        m_valid2, m_sel2, m_last2;
    logic [3:0]  m_index2;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    mode = 0;
    bit    rnd_ready = 1'b0;
    int    n_xfer = 0;
    int    n_xfer2 = 0;
    int    last_xfer_cyc = 0;
    beat_t exp_q[$];

    int F1_LIST[10] = '{0, 1, 2, 3, 4, 6, 8, 9, 10, 11};
    int F2_LIST[8]  = '{3, 5, 7, 8, 10, 11, 13, 15};

    function automatic logic in_f1(input logic [3:0] i);
        return int'(i) inside {0, 1, 2, 3, 4, 6, 8, 9, 10, 11};
    endfunction

    function automatic logic in_f2(input logic [3:0] i);
        return int'(i) inside {3, 5, 7, 8, 10, 11, 13, 15};
    endfunction

    // mode 0: lab functions, 1: f1=0 f2=1, 2: both zero
    assign f1   = (mode == 0) ? in_f1({A, B, C, D}) : 1'b0;
    assign f2   = (mode == 0) ? in_f2({A, B, C, D}) : (mode == 1);
    assign f1_2 = in_f1({A2, B2, C2, D2});
    assign f2_2 = in_f2({A2, B2, C2, D2});

    minterm_scanner #(.SAMPLE_DLY(0)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .A(A), .B(B), .C(C), .D(D), .f1(f1), .f2(f2),
        .mask1(mask1), .mask2(mask2), .m_valid(m_valid), .m_ready(m_ready),
        .m_sel(m_sel), .m_index(m_index), .m_last(m_last)
    );

    minterm_scanner #(.SAMPLE_DLY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .A(A2), .B(B2), .C(C2), .D(D2), .f1(f1_2), .f2(f2_2),
        .mask1(mask1_2), .mask2(mask2_2), .m_valid(m_valid2), .m_ready(1'b1),
        .m_sel(m_sel2), .m_index(m_index2), .m_last(m_last2)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer is matched against the scoreboard; stalls must hold.
    bit   stalled = 1'b0;
    logic [5:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(m_valid), 32'(1));
                check("stall_fields", 32'({m_sel, m_index, m_last}), 32'(held));
            end
            if (m_valid && m_ready) begin
                n_xfer++;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_unexpected: got sel=%0d idx=%0d, wanted no beat", m_sel, m_index);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_sel", 32'(m_sel), 32'(e.sel));
                    check("beat_idx", 32'(m_index), 32'(e.idx));
                    check("beat_last", 32'(m_last), 32'(e.last));
                end
            end
            stalled = m_valid && !m_ready;
            held    = {m_sel, m_index, m_last};
        end
        if (m_valid2) n_xfer2++;
    end

    task automatic push_beats(input int md);
        beat_t b;
        if (md == 0) begin
            for (int i = 0; i < 10; i++) begin
                b.sel = 1'b0; b.idx = 4'(F1_LIST[i]); b.last = 1'b0;
                exp_q.push_back(b);
            end
            for (int i = 0; i < 8; i++) begin
                b.sel = 1'b1; b.idx = 4'(F2_LIST[i]); b.last = (i == 7);
                exp_q.push_back(b);
            end
        end else if (md == 1) begin
            for (int i = 0; i < 16; i++) begin
                b.sel = 1'b1; b.idx = 4'(i); b.last = (i == 15);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start(input bit second);
        @(posedge clk);
        #1;
        if (second) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic run_scan(input int md, input bit chk_len, input logic [15:0] e1,
                            input logic [15:0] e2, input int n_beats);
        int busy_cnt;
        int x0;
        int done_cyc;
        bit seen;
        busy_cnt = 0;
        seen = 1'b0;
        done_cyc = 0;
        mode = md;
        push_beats(md);
        x0 = n_xfer;
        pulse_start(1'b0);
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                check("busy_low_at_done", 32'(busy), 32'(0));
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done in 3000 cycles, wanted done");
        end
        if (chk_len) check("busy_len", 32'(busy_cnt), 32'(48));
        check("mask1", 32'(mask1), 32'(e1));
        check("mask2", 32'(mask2), 32'(e2));
        check("n_beats", 32'(n_xfer - x0), 32'(n_beats));
        check("beats_left", 32'(exp_q.size()), 32'(0));
        if (n_beats > 0) check("done_after_last", 32'(done_cyc - last_xfer_cyc), 32'(1));
        @(negedge clk);
        check("done_width", 32'(done), 32'(0));
        check("mask1_hold", 32'(mask1), 32'(e1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_beat", 32'({m_valid, m_last, m_sel, m_index}), 32'(0));
        check("rst_abcd", 32'({A, B, C, D}), 32'(0));
        check("rst_masks", 32'({mask2, mask1}), 32'(0));
        rst = 1'b0;

        run_scan(0, 1'b1, 16'h0F5F, 16'hADA8, 18);

        rnd_ready = 1'b1;
        run_scan(0, 1'b0, 16'h0F5F, 16'hADA8, 18);
        rnd_ready = 1'b0;

        run_scan(1, 1'b1, 16'h0000, 16'hFFFF, 16);
        run_scan(2, 1'b1, 16'h0000, 16'h0000, 0);

        // Abort mid-sweep at vector 7, then rescan.
        mode = 0;
        pulse_start(1'b0);
        begin
            bit hit7;
            hit7 = 1'b0;
            for (int k = 0; k < 40 && !hit7; k++) begin
                @(negedge clk);
                if ({A, B, C, D} == 4'd7) hit7 = 1'b1;
            end
            check("abort_reached_v7", 32'(hit7), 32'(1));
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_abcd", 32'({A, B, C, D}), 32'(0));
        check("abort_masks", 32'({mask2, mask1}), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'(0));
        run_scan(0, 1'b1, 16'h0F5F, 16'hADA8, 18);

        // Slow-settle instance: three cycles per vector.
        n_xfer2 = 0;
        pulse_start(1'b1);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            check("dly_abcd", 32'({A2, B2, C2, D2}), 32'(k / 3));
            if (k == 47) check("dly_no_beat_in_drive", 32'(m_valid2), 32'(0));
        end
        @(negedge clk);
        check("dly_first_beat", 32'(m_valid2), 32'(1));
        begin
            bit seen2;
            seen2 = 1'b0;
            for (int k = 0; k < 200 && !seen2; k++) begin
                @(negedge clk);
                if (done2) seen2 = 1'b1;
            end
            check("dly_done", 32'(seen2), 32'(1));
        end
        check("dly_mask1", 32'(mask1_2), 32'(16'h0F5F));
        check("dly_mask2", 32'(mask2_2), 32'(16'hADA8));
        check("dly_beats", 32'(n_xfer2), 32'(18));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
